// File: rtl/barrera_pkg.sv
// Shared constants for the parking-lot barrier controller: state encodings,
// default travel/hold times and the full-lot blink half-period.
package barrera_pkg;

    localparam logic [2:0] CERRADA  = 3'd0;
    localparam logic [2:0] ABRIENDO = 3'd1;
    localparam logic [2:0] ABIERTA  = 3'd2;
    localparam logic [2:0] CERRANDO = 3'd3;

    localparam int unsigned T_MOVE_DEF = 500;
    localparam int unsigned T_OPEN_DEF = 3000;

    localparam int unsigned BLINK_HALF = 250;

    // Exit is always allowed; entry only while the lot has room.
    function automatic logic acepta(input logic ent, input logic sal, input logic full);
        return sal | (ent & ~full);
    endfunction

endpackage

// File: rtl/barrera_ctrl_ms_timer.sv
// Millisecond down-counter: load wins over tick, done flags the tick that
// brings the count from 1 to 0.
module ms_timer #(
    parameter int unsigned TW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic [TW-1:0] cnt,
    output logic          done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign done = tick && (cnt == TW'(1));

endmodule

// File: rtl/barrera_ctrl.sv
// Gate-barrier controller: open/hold/close FSM timed in ms, refuses entry
// while full. Optional full-lot red-light blink under `FULL_BLINK_EN.
module barrera_ctrl
    import barrera_pkg::*;
#(
    parameter int unsigned T_MOVE = T_MOVE_DEF,
    parameter int unsigned T_OPEN = T_OPEN_DEF,
    parameter int unsigned TW     = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tick_ms,
    input  logic       ent_req,
    input  logic       sal_req,
    input  logic       lleno,
    output logic       motor_abrir,
    output logic       motor_cerrar,
    output logic       barrera_abierta,
    output logic       luz_verde,
    output logic       luz_roja,
    output logic       rechazo,
    output logic [2:0] estado
);

    localparam logic [TW-1:0] TM = TW'(T_MOVE);
    localparam logic [TW-1:0] TO = TW'(T_OPEN);

    logic          acc;
    logic [2:0]    nstate;
    logic          tload;
    logic [TW-1:0] tval;
    logic [TW-1:0] tcnt;
    logic          tdone;
    logic          verde_nx;
    logic          roja_nx;

    ms_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tload),
        .load_val (tval),
        .tick     (tick_ms),
        .cnt      (tcnt),
        .done     (tdone)
    );

    always_comb begin
        acc    = acepta(ent_req, sal_req, lleno);
        nstate = estado;
        tload  = 1'b0;
        tval   = TM;
        case (estado)
            CERRADA: begin
                if (acc) begin
                    nstate = ABRIENDO;
                    tload  = 1'b1;
                    tval   = TM;
                end
            end
            ABRIENDO: begin
                if (tdone) begin
                    nstate = ABIERTA;
                    tload  = 1'b1;
                    tval   = TO;
                end
            end
            ABIERTA: begin
                if (acc) begin
                    tload = 1'b1;
                    tval  = TO;
                end else if (tdone) begin
                    nstate = CERRANDO;
                    tload  = 1'b1;
                    tval   = TM;
                end
            end
            CERRANDO: begin
                // Reopen for the distance already travelled; a reversal right at
                // the start of closing would otherwise load 0 and never expire.
                if (acc) begin
                    nstate = ABRIENDO;
                    tload  = 1'b1;
                    tval   = (tcnt == TM) ? TW'(1) : (TM - tcnt);
                end else if (tdone) begin
                    nstate = CERRADA;
                end
            end
            default: begin
                nstate = CERRADA;
            end
        endcase
        verde_nx = (nstate == ABIERTA);
    end

`ifdef FULL_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_fase;
    logic       blink_act;
    logic       fase_nx;

    always_comb begin
        blink_act = lleno && (nstate == CERRADA);
        fase_nx   = blink_fase;
        if (!blink_act) begin
            fase_nx = 1'b1;
        end else if (tick_ms && (blink_cnt == 8'(BLINK_HALF - 1))) begin
            fase_nx = ~blink_fase;
        end
        roja_nx = blink_act ? fase_nx : ~verde_nx;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_cnt  <= '0;
            blink_fase <= 1'b1;
        end else begin
            blink_fase <= fase_nx;
            if (!blink_act) begin
                blink_cnt <= '0;
            end else if (tick_ms) begin
                blink_cnt <= (blink_cnt == 8'(BLINK_HALF - 1)) ? '0 : blink_cnt + 8'd1;
            end
        end
    end
`else
    assign roja_nx = ~verde_nx;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            estado          <= CERRADA;
            motor_abrir     <= 1'b0;
            motor_cerrar    <= 1'b0;
            barrera_abierta <= 1'b0;
            luz_verde       <= 1'b0;
            luz_roja        <= 1'b1;
            rechazo         <= 1'b0;
        end else begin
            estado          <= nstate;
            motor_abrir     <= (nstate == ABRIENDO);
            motor_cerrar    <= (nstate == CERRANDO);
            barrera_abierta <= (nstate == ABIERTA);
            luz_verde       <= verde_nx;
            luz_roja        <= roja_nx;
            rechazo         <= ent_req & lleno;
        end
    end

endmodule

// File: doc/barrera_ctrl.md
# barrera_ctrl

Gate-barrier controller that sits directly downstream of the entry/exit sequence detector and the occupancy counter in the parking-lot design. It consumes the single-cycle entry/exit pulses and the counter's `lleno` flag. It drives the barrier motor and the red/green lights through an open/hold/close state machine timed in milliseconds. Entry requests are refused while the lot is full, and each refusal is reported with a pulse.

## Interface
Parameters:
- `T_MOVE`, 500, barrier travel time in ms (opening or closing), 1..4095
- `T_OPEN`, 3000, hold-open time in ms, 1..4095
- `TW`, 12, timer width in bits; must satisfy 2^TW > max(T_MOVE, T_OPEN)

Ports:
- `CLK` in 1: system clock (12 MHz)
- `RST` in 1: asynchronous, active-high reset
- `tick_ms` in 1: single-cycle strobe once per ms, synchronous to `CLK`
- `ent_req` in 1: single-cycle pulse, vehicle requests entry
- `sal_req` in 1: single-cycle pulse, vehicle requests exit
- `lleno` in 1: lot full, level, from the occupancy counter
- `motor_abrir` out 1: drive barrier open
- `motor_cerrar` out 1: drive barrier closed
- `barrera_abierta` out 1: barrier fully open
- `luz_verde` out 1: green light
- `luz_roja` out 1: red light
- `rechazo` out 1: single-cycle pulse, entry refused
- `estado` out 3: current state encoding, for LEDs and debug

## Operation
- States: CERRADA=0, ABRIENDO=1, ABIERTA=2, CERRANDO=3.
- A request is "accepted" when `sal_req` is high, or when `ent_req` is high and `lleno` is low.
- CERRADA:
  - On an accepted request, go to ABRIENDO and load the timer with `T_MOVE`.
  - Otherwise stay.
- ABRIENDO:
  - `motor_abrir` is 1.
  - The timer decrements on each `tick_ms`.
  - On the tick that reaches 0, go to ABIERTA and load `T_OPEN`.
  - Requests arriving in this state are ignored, but refusals still pulse.
- ABIERTA:
  - `barrera_abierta` and `luz_verde` are 1.
  - An accepted request reloads `T_OPEN`.
  - When the timer expires, go to CERRANDO and load `T_MOVE`.
- CERRANDO:
  - `motor_cerrar` is 1.
  - An accepted request reverses the barrier: go to ABRIENDO with timer = `T_MOVE` − remaining.
  - If the remaining count equals `T_MOVE`, the reload value is clamped to 1.
  - When the timer expires, go to CERRADA.
- `luz_roja` = NOT `luz_verde`.
- `rechazo` = 1 for exactly one cycle after any cycle with `ent_req` & `lleno`, in every state. This holds even when a simultaneous `sal_req` is accepted.
- `motor_abrir` and `motor_cerrar` are never both 1.
- Reset values: state CERRADA, timer 0, `motor_abrir`/`motor_cerrar`/`barrera_abierta`/`luz_verde`/`rechazo` = 0, `luz_roja` = 1, `estado` = 0.
- Asserting `RST` in any state, including mid-travel, returns the block to CERRADA immediately. No closing travel is performed.

## Timing
- All outputs are registered.
- A request in cycle n gives the new state and outputs in cycle n+1.
- ABRIENDO lasts exactly `T_MOVE` `tick_ms` strobes; ABIERTA exactly `T_OPEN` strobes after its last reload.
- A state transition on timer expiry occurs in the cycle after the expiring `tick_ms`.
- Request and tick in the same cycle:
  - An accepted request takes priority over expiry. ABIERTA reloads; CERRANDO reverses.
  - The tick does not decrement the freshly loaded value.
- `ent_req` and `sal_req` together while not full count as a single accepted request.

## Configuration
- `FULL_BLINK_EN` defined:
  - While `lleno` = 1 and state = CERRADA, `luz_roja` toggles every 250 `tick_ms` (2 Hz).
  - The toggle starts high on `lleno` rising.
  - Outside that condition the steady rule applies.
  - Adds one 8-bit counter and one flop.
- `FULL_BLINK_EN` undefined: `luz_roja` is always NOT `luz_verde`.

## Structure
- Package `barrera_pkg` holds:
  - the state encoding localparams (CERRADA..CERRANDO);
  - default `T_MOVE` / `T_OPEN`;
  - the blink half-period constant (250).
- Sub-module `ms_timer` (`TW` bits) provides:
  - `load`, `load_val`, `tick` inputs;
  - a `cnt` output;
  - a `done` output asserted when `tick` arrives with `cnt` = 1.

## Test plan
Bench parameters: `T_MOVE`=4, `T_OPEN`=10, `tick_ms` every 5 cycles.
- Reset, then `ent_req` with `lleno`=0:
  - `estado`=1 next cycle;
  - 2 after 4 ticks;
  - 3 after 10 more ticks;
  - 0 after 4 more ticks;
  - `luz_verde` high only in state 2.
- `ent_req` with `lleno`=1 in CERRADA → `rechazo` pulses for 1 cycle; `estado` stays 0.
- `sal_req` with `lleno`=1 → barrier opens normally and `rechazo` stays 0.
- In ABIERTA, `sal_req` at 7 ticks elapsed → state 3 is reached only 10 ticks after the request.
- In CERRANDO with 3 ticks remaining, `ent_req` → ABRIENDO; ABIERTA is reached 1 tick later.
- `RST` during ABRIENDO → `estado`=0 and both motors 0 immediately.
- With `FULL_BLINK_EN` defined: `lleno`=1 in CERRADA → `luz_roja` toggles every 250 ticks.
